// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_ctrl_pkg;

    typedef enum logic {
        MODE_BUBBLE    = 1'b0,
        MODE_INTERLOCK = 1'b1
    } mode_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    localparam int NUM_STAGES = 5;

    localparam int F_IDX = 0;
    localparam int D_IDX = 1;
    localparam int E_IDX = 2;
    localparam int M_IDX = 3;
    localparam int W_IDX = 4;

endpackage

// File: rtl/hazard_ctrl_mc_fsm.sv
// Multi-cycle execute tracker: holds E (and everything upstream) for N-1 cycles
// of an N-cycle op. The FSM state is exported for observation.
module hazard_ctrl_mc_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start,
    input  logic [MC_CNT_W-1:0] cycles,
    input  logic                freeze,
    output logic                mc_stall,
    output mc_state_e           state
);

    mc_state_e           state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        case (state_q)
            MC_IDLE: begin
                // The first stall cycle is the one in which the op enters E.
                if (start && (cycles > MC_CNT_W'(1))) begin
                    mc_stall = 1'b1;
                    if (!freeze) begin
                        cnt_d   = cycles - MC_CNT_W'(2);
                        state_d = (cycles > MC_CNT_W'(2)) ? MC_BUSY : MC_IDLE;
                    end
                end
            end
            MC_BUSY: begin
                mc_stall = 1'b1;
                if (!freeze) begin
                    if (cnt_q == MC_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = MC_IDLE;
                    end else begin
                        cnt_d = cnt_q - MC_CNT_W'(1);
                    end
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the F-D-E-M-W pipeline: fixed-period bubbling or
// hazard interlocking, plus a saturating front-end stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter mode_e MODE         = MODE_INTERLOCK,
    parameter int    BUBBLE_DEPTH = 4,
    parameter int    REG_AW       = 5,
    parameter int    MC_CNT_W     = 4,
    parameter int    STAT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_AW-1:0]     d_rs1_addr_i,
    input  logic [REG_AW-1:0]     d_rs2_addr_i,
    input  logic                  d_rs1_used_i,
    input  logic                  d_rs2_used_i,
    input  logic                  e_load_i,
    input  logic [REG_AW-1:0]     e_rd_addr_i,
    input  logic                  e_branch_taken_i,
    input  logic                  e_mc_start_i,
    input  logic [MC_CNT_W-1:0]   e_mc_cycles_i,
    input  logic                  m_busy_i,
    input  logic                  clr_stats_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-2:0] flush_o,
    output logic [STAT_W-1:0]     stall_cycles_o
);

    localparam int TW = (BUBBLE_DEPTH < 1) ? 1 : $clog2(BUBBLE_DEPTH + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(BUBBLE_DEPTH);

    logic [TW-1:0] timer_q;
    logic          mc_stall;
    mc_state_e     mc_state;
    logic          load_use;
    logic          interlock;

    assign interlock = (MODE == MODE_INTERLOCK);

    // Bubble timer; value 0 is the issue slot, so issue happens right after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (!interlock && !m_busy_i) begin
            timer_q <= (timer_q == TIMER_MAX) ? '0 : timer_q + TW'(1);
        end
    end

    hazard_ctrl_mc_fsm #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_fsm (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (e_mc_start_i && interlock),
        .cycles   (e_mc_cycles_i),
        .freeze   (m_busy_i),
        .mc_stall (mc_stall),
        .state    (mc_state)
    );

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = e_load_i && (e_rd_addr_i != '0) &&
                      ((d_rs1_used_i && (d_rs1_addr_i == e_rd_addr_i)) ||
                       (d_rs2_used_i && (d_rs2_addr_i == e_rd_addr_i)));

    always_comb begin
        stall_o = '0;
        flush_o = '0;
        if (rst_i) begin
            stall_o = '0;
            flush_o = '0;
        end else if (m_busy_i) begin
            stall_o[M_IDX:F_IDX] = '1;
            flush_o[M_IDX]       = 1'b1;
        end else if (!interlock) begin
            if (timer_q != '0) begin
                stall_o[F_IDX] = 1'b1;
                flush_o[F_IDX] = 1'b1;
            end
        end else if (mc_stall || (mc_state == MC_BUSY)) begin
            stall_o[E_IDX:F_IDX] = '1;
            flush_o[E_IDX]       = 1'b1;
        end else if (e_branch_taken_i) begin
            flush_o[D_IDX:F_IDX] = '1;
        end else if (load_use) begin
            stall_o[D_IDX:F_IDX] = '1;
            flush_o[D_IDX]       = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
        end else if (clr_stats_i) begin
            stall_cycles_o <= '0;
        end else if (stall_o[F_IDX] && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + STAT_W'(1);
        end
    end

endmodule
